// File: rtl/arith_accel_pkg.sv
// Shared definitions for the Wishbone arithmetic accelerator: operation
// codes, CSR word indices, CTRL/STATUS bit positions and FSM states.
package arith_accel_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // CSR word indices (byte offset >> 2)
    localparam logic [2:0] REG_RES_LO = 3'd0;
    localparam logic [2:0] REG_OP_A   = 3'd1;
    localparam logic [2:0] REG_OP_B   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_RES_HI = 3'd5;

    localparam int CTRL_START_BIT = 8;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;

    // The reserved encoding 3 behaves as ADD.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:    return OP_SUB;
            2'd2:    return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/wb_arith_accel_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is consumed on the start edge, the remaining DATA_W-1 bits on the
// following edges, so the product is final DATA_W-1 edges after start.
// done is high during the last iteration cycle: the product is valid
// immediately after the edge that ends that cycle.
module seq_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;

    // Load operands (consuming bit 0) on start, then one shift-add per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_acc    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
            r_mcand  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
            r_mplier <= b >> 1;
            r_cnt    <= CNT_W'(DATA_W - 1);
        end else if (r_cnt != '0) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    assign busy    = (r_cnt != '0);
    assign done    = (r_cnt == CNT_W'(1));
    assign product = r_acc;

endmodule

// File: rtl/wb_arith_accel.sv
// Wishbone CSR arithmetic accelerator: ADD/SUB in one cycle, MUL via a
// sequential shift-add unit, double-width result, busy/done status.
// Optional macro ARITH_ACCEL_SAT_EN: ADD/SUB saturate on signed overflow.
module wb_arith_accel
    import arith_accel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADR_W-1:0]  wb_adr,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_ack,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              busy
);

    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic                r_ack;
    logic [DATA_W-1:0]   r_dat_o;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [1:0]          r_ctrl_op;
    op_e                 r_op_sel;
    logic [DATA_W-1:0]   r_res_lo;
    logic [DATA_W-1:0]   r_res_hi;
    logic                r_done;
    logic                r_ovf;
    state_e              r_state;
    state_e              w_state_next;

    logic [31:0]         w_adr32;
    logic [31:0]         w_wdat32;
    logic [31:0]         w_rd32;
    logic [2:0]          w_idx;
    logic                w_acc;
    logic                w_wr;
    logic                w_busy;
    logic                w_start;
    logic                w_done_clr;
    op_e                 w_new_op;
    logic                w_mul_busy;
    logic                w_mul_last;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_as_lo;
    logic [DATA_W-1:0]   w_as_hi;
    logic                w_as_ovf;
    logic                w_unused_bits;

    assign w_adr32    = 32'(wb_adr);
    assign w_wdat32   = 32'(wb_dat_i);
    assign w_idx      = w_adr32[4:2];
    assign w_acc      = wb_cyc & wb_stb & ~r_ack;
    assign w_wr       = w_acc & wb_we;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_new_op   = decode_op(w_wdat32[1:0]);
    // START is only honoured from IDLE; a START while busy is silently dropped
    assign w_start    = w_wr && (w_idx == REG_CTRL) && w_wdat32[CTRL_START_BIT] && !w_busy;
    assign w_done_clr = w_wr && (w_idx == REG_STATUS) && w_wdat32[STAT_DONE_BIT];
    assign w_unused_bits = ^{w_adr32[31:5], w_adr32[1:0], w_wdat32[31:9], w_wdat32[7:2], w_mul_busy};

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start && (w_new_op == OP_MUL)),
        .a       (r_op_a),
        .b       (r_op_b),
        .busy    (w_mul_busy),
        .done    (w_mul_last),
        .product (w_product)
    );

    // Read mux, assembled at 32 bits and truncated to the bus width
    always_comb begin
        w_rd32 = '0;
        case (w_idx)
            REG_RES_LO: w_rd32 = 32'(r_res_lo);
            REG_OP_A:   w_rd32 = 32'(r_op_a);
            REG_OP_B:   w_rd32 = 32'(r_op_b);
            REG_CTRL:   w_rd32 = 32'(r_ctrl_op);
            REG_STATUS: w_rd32 = 32'({r_ovf, r_done, w_busy});
            REG_RES_HI: w_rd32 = 32'(r_res_hi);
            default:    w_rd32 = '0;
        endcase
    end

    // ADD/SUB datapath from the latched operands, with optional saturation
    always_comb begin
        w_sum  = {1'b0, r_op_a} + {1'b0, r_op_b};
        w_diff = {1'b0, r_op_a} - {1'b0, r_op_b};
        if (r_op_sel == OP_SUB) begin
            w_as_lo  = w_diff[DATA_W-1:0];
            w_as_hi  = DATA_W'(w_diff[DATA_W]);
            w_as_ovf = (r_op_a[DATA_W-1] != r_op_b[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != r_op_a[DATA_W-1]);
        end else begin
            w_as_lo  = w_sum[DATA_W-1:0];
            w_as_hi  = DATA_W'(w_sum[DATA_W]);
            w_as_ovf = (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != r_op_a[DATA_W-1]);
        end
`ifdef ARITH_ACCEL_SAT_EN
        // An overflowing result always lands on the side of A's sign
        if (w_as_ovf) begin
            w_as_lo = r_op_a[DATA_W-1] ? SMIN : SMAX;
            w_as_hi = '0;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = (w_new_op == OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_mul_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Bus handshake: one-cycle ack pulse, read data registered with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_acc;
            r_dat_o <= w_acc ? DATA_W'(w_rd32) : '0;
        end
    end

    // Operand/control CSRs; frozen while an operation is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_ctrl_op <= '0;
            r_op_sel  <= OP_ADD;
        end else begin
            if (w_wr && !w_busy) begin
                case (w_idx)
                    REG_OP_A: r_op_a    <= wb_dat_i;
                    REG_OP_B: r_op_b    <= wb_dat_i;
                    REG_CTRL: r_ctrl_op <= w_wdat32[1:0];
                    default: ;
                endcase
            end
            if (w_start) r_op_sel <= w_new_op;
        end
    end

    // Result capture in DONE; done flag set there (set beats a clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_state == ST_DONE) begin
            if (r_op_sel == OP_MUL) begin
                r_res_lo <= w_product[DATA_W-1:0];
                r_res_hi <= w_product[2*DATA_W-1:DATA_W];
                r_ovf    <= (w_product[2*DATA_W-1:DATA_W] != '0);
            end else begin
                r_res_lo <= w_as_lo;
                r_res_hi <= w_as_hi;
                r_ovf    <= w_as_ovf;
            end
            r_done <= 1'b1;
        end else if (w_start || w_done_clr) begin
            r_done <= 1'b0;
        end
    end

    assign wb_ack   = r_ack;
    assign wb_dat_o = r_dat_o;
    assign busy     = w_busy;

endmodule

// File: tb/tb_wb_arith_accel.sv
// Self-checking bench for wb_arith_accel (DATA_W = 32): directed cases
// followed by randomized operations against a plain-arithmetic model.
module tb_wb_arith_accel;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic [31:0] wb_dat_o;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Shadow state of the register file
    logic [31:0] m_op_a, m_op_b, m_res_lo, m_res_hi;
    logic [1:0]  m_ctrl;
    logic        m_done, m_ovf;

    wb_arith_accel #(.DATA_W(W), .ADR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack),
        .wb_dat_o (wb_dat_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer starting from an idle bus; checks ack latency
    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int lat;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb_ack && lat < 8);
        rdat = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        chk("ack_latency", 64'(lat), 64'd1);
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
        $display("WR  adr=0x%02h data=0x%08h", adr, wdat);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, adr, 32'h0, rd);
        $display("RD  %s adr=0x%02h data=0x%08h expected=0x%08h", tag, adr, rd, exp);
        chk(tag, 64'(rd), 64'(exp));
    endtask

    function automatic logic [31:0] status_exp();
        return {29'd0, m_ovf, m_done, 1'b0};
    endfunction

    // Reference results computed directly from the arithmetic definitions
    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint unsigned ua, ub, full;
        longint sa, sb, tr;
        ua = 64'(a); ub = 64'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (op == 2'd2) begin
            full = ua * ub;
            m_res_lo = full[31:0];
            m_res_hi = full[63:32];
            m_ovf    = (m_res_hi != 0);
        end else begin
            if (op == 2'd1) begin
                tr = sa - sb;
                m_res_lo = 32'(ua - ub);
                m_res_hi = (ua < ub) ? 32'd1 : 32'd0;
            end else begin
                tr = sa + sb;
                full = ua + ub;
                m_res_lo = full[31:0];
                m_res_hi = full[63:32];
            end
            m_ovf = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
`ifdef ARITH_ACCEL_SAT_EN
            if (m_ovf) begin
                m_res_lo = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                m_res_hi = 32'd0;
            end
`endif
        end
        m_done = 1'b1;
    endtask

    // Full operation: load, start, measure busy length, check results, clear done
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
        int cnt;
        wb_write(5'h04, a); m_op_a = a;
        wb_write(5'h08, b); m_op_b = b;
        wb_write(5'h0C, 32'h100 | 32'(op)); m_ctrl = op; m_done = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        model_op(a, b, op);
        $display("OP  %s op=%0d a=0x%08h b=0x%08h busy_cycles=%0d", tag, op, a, b, cnt);
        chk({tag, "_busy_cycles"}, 64'(cnt), (op == 2'd2) ? 64'(W) : 64'd1);
        rd_chk({tag, "_res_lo"}, 5'h00, m_res_lo);
        rd_chk({tag, "_res_hi"}, 5'h14, m_res_hi);
        rd_chk({tag, "_status"}, 5'h10, status_exp());
        rd_chk({tag, "_ctrl"},   5'h0C, {30'd0, m_ctrl});
        wb_write(5'h10, 32'h2); m_done = 1'b0;
        rd_chk({tag, "_status_clr"}, 5'h10, status_exp());
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 4))
                0: return 32'h0000_0000;
                1: return 32'h0000_0001;
                2: return 32'h7FFF_FFFF;
                3: return 32'h8000_0000;
                default: return 32'hFFFF_FFFF;
            endcase
        end
        return $urandom();
    endfunction

    task automatic model_reset();
        m_op_a = 0; m_op_b = 0; m_res_lo = 0; m_res_hi = 0;
        m_ctrl = 0; m_done = 0; m_ovf = 0;
    endtask

    initial begin
        int cnt;
        logic [31:0] a, b;
        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_i = 0;
        model_reset();

        // Reset state
        #3;
        chk("rst_ack", 64'(wb_ack), 64'd0);
        chk("rst_dat_o", 64'(wb_dat_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", 5'(i * 4), 32'd0);

        // Directed arithmetic cases
        run_op("add_carry", 32'hFFFF_FFFF, 32'h2, 2'd0);
        run_op("sub_ovf",   32'h8000_0000, 32'h1, 2'd1);
        run_op("mul_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2);
        run_op("mul_zero",  32'h0, 32'h1234_5678, 2'd2);
        run_op("op3_add",   32'h7FFF_FFFF, 32'h1, 2'd3);

        // Writes while busy are acked but ignored; START while busy ignored
        wb_write(5'h04, 32'd3); m_op_a = 3;
        wb_write(5'h08, 32'd5); m_op_b = 5;
        wb_write(5'h0C, 32'h102); m_ctrl = 2'd2;
        wb_write(5'h04, 32'd9);
        wb_write(5'h0C, 32'h101);
        chk("prot_busy_mid", 64'(busy), 64'd1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin cnt++; @(posedge clk); #1; end
        chk("prot_busy_timeout", 64'(cnt < 100), 64'd1);
        model_op(3, 5, 2'd2);
        rd_chk("prot_res_lo", 5'h00, 32'd15);
        rd_chk("prot_op_a", 5'h04, 32'd3);
        rd_chk("prot_ctrl", 5'h0C, 32'd2);
        rd_chk("prot_status", 5'h10, status_exp());

        // Bus protocol: back-to-back reads, ack every other cycle
        @(posedge clk); #1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 5'h1C;
        @(posedge clk); #1;
        chk("b2b_ack0", 64'(wb_ack), 64'd1);
        chk("b2b_dat0", 64'(wb_dat_o), 64'd0);
        wb_adr = 5'h04;
        @(posedge clk); #1;
        chk("b2b_gap_ack", 64'(wb_ack), 64'd0);
        chk("b2b_gap_dat", 64'(wb_dat_o), 64'd0);
        @(posedge clk); #1;
        chk("b2b_ack1", 64'(wb_ack), 64'd1);
        chk("b2b_dat1", 64'(wb_dat_o), 64'(m_op_a));
        wb_cyc = 0; wb_stb = 0;
        $display("B2B reads 0x1C then 0x04 done");
        wb_write(5'h10, 32'h2); m_done = 1'b0;
        rd_chk("w1c_status", 5'h10, status_exp());
        wb_write(5'h00, 32'hDEAD_BEEF);
        wb_write(5'h18, 32'hDEAD_BEEF);
        rd_chk("ro_res_lo", 5'h00, m_res_lo);
        rd_chk("rsvd_18", 5'h18, 32'd0);

        // Reset in the middle of a MUL
        wb_write(5'h04, 32'h1234_5678);
        wb_write(5'h08, 32'h9ABC_DEF0);
        wb_write(5'h0C, 32'h102);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_ack", 64'(wb_ack), 64'd0);
        chk("mrst_dat_o", 64'(wb_dat_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        $display("RST asserted mid-MUL");
        for (int i = 0; i < 8; i++) rd_chk("mrst_reg", 5'(i * 4), 32'd0);
        run_op("post_rst_add", 32'd1, 32'd1, 2'd0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            a = pick();
            b = pick();
            run_op("rand", a, b, 2'($urandom_range(0, 3)));
            rd_chk("rand_op_a", 5'h04, m_op_a);
            rd_chk("rand_op_b", 5'h08, m_op_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
